// File: rtl/writeback_unit.sv
// Final pipeline stage: retires execute results and merges returning load data into GPR/FPR/CR write ports.
// Optional macro WB_FORWARD_EN adds combinational forwarding outputs derived from the registered write ports.
module writeback_unit #(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeback_en,
    input  logic [31:0] dout,
    input  logic [31:0] f_dout,
    input  logic [3:0]  cr_wdata,
    input  logic [2:0]  wb_sel,
    input  logic [4:0]  wb_rd,
    input  logic [2:0]  cr_field,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        fpr_we,
    output logic [4:0]  fpr_waddr,
    output logic [31:0] fpr_wdata,
    output logic        cr_we,
    output logic [2:0]  cr_wfield,
    output logic [3:0]  cr_wval,
    output logic        wb_busy,
    output logic        wb_done,
    output logic        load_timeout,
    output logic        wb_overrun
`ifdef WB_FORWARD_EN
    ,
    output logic        fwd_valid,
    output logic        fwd_is_fpr,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_WAIT_MEM = 1'b1;

    localparam logic [2:0] SEL_GPR     = 3'd1;
    localparam logic [2:0] SEL_FPR     = 3'd2;
    localparam logic [2:0] SEL_CR      = 3'd3;
    localparam logic [2:0] SEL_LD_GPR  = 3'd4;
    localparam logic [2:0] SEL_LD_FPR  = 3'd5;

    // Timeout fires on the WAIT_MEM cycle whose increment would reach LOAD_TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

    logic       state;
    logic [7:0] wait_cnt;
    logic [4:0] ld_rd;
    logic [2:0] ld_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            ld_rd        <= '0;
            ld_sel       <= '0;
            gpr_we       <= 1'b0;
            gpr_waddr    <= '0;
            gpr_wdata    <= '0;
            fpr_we       <= 1'b0;
            fpr_waddr    <= '0;
            fpr_wdata    <= '0;
            cr_we        <= 1'b0;
            cr_wfield    <= '0;
            cr_wval      <= '0;
            wb_busy      <= 1'b0;
            wb_done      <= 1'b0;
            load_timeout <= 1'b0;
            wb_overrun   <= 1'b0;
        end else begin
            gpr_we  <= 1'b0;
            fpr_we  <= 1'b0;
            cr_we   <= 1'b0;
            wb_done <= 1'b0;

            if (state == ST_IDLE) begin
                if (writeback_en) begin
                    case (wb_sel)
                        SEL_GPR: begin
                            gpr_we    <= 1'b1;
                            gpr_waddr <= wb_rd;
                            gpr_wdata <= dout;
                            wb_done   <= 1'b1;
                        end
                        SEL_FPR: begin
                            fpr_we    <= 1'b1;
                            fpr_waddr <= wb_rd;
                            fpr_wdata <= f_dout;
                            wb_done   <= 1'b1;
                        end
                        SEL_CR: begin
                            cr_we     <= 1'b1;
                            cr_wfield <= cr_field;
                            cr_wval   <= cr_wdata;
                            wb_done   <= 1'b1;
                        end
                        SEL_LD_GPR, SEL_LD_FPR: begin
                            state    <= ST_WAIT_MEM;
                            wb_busy  <= 1'b1;
                            wait_cnt <= '0;
                            ld_rd    <= wb_rd;
                            ld_sel   <= wb_sel;
                        end
                        default: begin
                            wb_done <= 1'b1;
                        end
                    endcase
                end
            end else begin
                if (writeback_en) begin
                    wb_overrun <= 1'b1;
                end
                // Returning data takes priority over an expiring timeout.
                if (mem_rvalid) begin
                    if (ld_sel == SEL_LD_FPR) begin
                        fpr_we    <= 1'b1;
                        fpr_waddr <= ld_rd;
                        fpr_wdata <= mem_rdata;
                    end else begin
                        gpr_we    <= 1'b1;
                        gpr_waddr <= ld_rd;
                        gpr_wdata <= mem_rdata;
                    end
                    wb_done  <= 1'b1;
                    wb_busy  <= 1'b0;
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    load_timeout <= 1'b1;
                    wb_done      <= 1'b1;
                    wb_busy      <= 1'b0;
                    state        <= ST_IDLE;
                    wait_cnt     <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

`ifdef WB_FORWARD_EN
    always_comb begin
        fwd_valid  = gpr_we | fpr_we;
        fwd_is_fpr = fpr_we;
        fwd_rd     = fpr_we ? fpr_waddr : gpr_waddr;
        fwd_data   = fpr_we ? fpr_wdata : gpr_wdata;
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit, built with LOAD_TIMEOUT=4.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        writeback_en;
    logic [31:0] dout;
    logic [31:0] f_dout;
    logic [3:0]  cr_wdata;
    logic [2:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic [2:0]  cr_field;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        fpr_we;
    logic [4:0]  fpr_waddr;
    logic [31:0] fpr_wdata;
    logic        cr_we;
    logic [2:0]  cr_wfield;
    logic [3:0]  cr_wval;
    logic        wb_busy;
    logic        wb_done;
    logic        load_timeout;
    logic        wb_overrun;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic        fwd_is_fpr;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks;
    int failures;

    writeback_unit #(.LOAD_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .writeback_en(writeback_en), .dout(dout), .f_dout(f_dout),
        .cr_wdata(cr_wdata), .wb_sel(wb_sel), .wb_rd(wb_rd), .cr_field(cr_field),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
        .cr_we(cr_we), .cr_wfield(cr_wfield), .cr_wval(cr_wval),
        .wb_busy(wb_busy), .wb_done(wb_done), .load_timeout(load_timeout), .wb_overrun(wb_overrun)
`ifdef WB_FORWARD_EN
        , .fwd_valid(fwd_valid), .fwd_is_fpr(fwd_is_fpr), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        writeback_en = 1'b0;
        mem_rvalid   = 1'b0;
        wb_sel       = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; quiet_inputs();
        dout = '0; f_dout = '0; cr_wdata = '0; wb_rd = '0; cr_field = '0; mem_rdata = '0;
        tick(); tick();
        checks++; if ({gpr_we, fpr_we, cr_we, wb_busy, wb_done, load_timeout, wb_overrun} !== 7'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000000", {gpr_we, fpr_we, cr_we, wb_busy, wb_done, load_timeout, wb_overrun}); end
        rst = 1'b0;
        tick();
        // Start a load, then reset in the middle of WAIT_MEM.
        writeback_en = 1'b1; wb_sel = 3'd4; wb_rd = 5'd5;
        tick();
        quiet_inputs();
        checks++; if (wb_busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy got=%b exp=1", wb_busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wb_busy !== 1'b0) begin failures++; $display("FAIL reset_async_busy got=%b exp=0", wb_busy); end
        #1 rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({gpr_we, fpr_we, wb_done, wb_busy} !== 4'b0) begin
            failures++; $display("FAIL reset_no_write got=%b exp=0000", {gpr_we, fpr_we, wb_done, wb_busy}); end
        checks++; if (gpr_wdata !== 32'h0) begin failures++; $display("FAIL reset_gpr_wdata got=%h exp=00000000", gpr_wdata); end
        tick();
    endtask

    task automatic test_alu();
        writeback_en = 1'b1; wb_sel = 3'd1; wb_rd = 5'd7; dout = 32'h0000_002A; f_dout = 32'h1111_1111;
        tick();
        quiet_inputs();
        checks++; if (gpr_we !== 1'b1) begin failures++; $display("FAIL alu_gpr_we got=%b exp=1", gpr_we); end
        checks++; if (gpr_waddr !== 5'd7) begin failures++; $display("FAIL alu_gpr_waddr got=%0d exp=7", gpr_waddr); end
        checks++; if (gpr_wdata !== 32'h2A) begin failures++; $display("FAIL alu_gpr_wdata got=%h exp=0000002a", gpr_wdata); end
        checks++; if (wb_done !== 1'b1) begin failures++; $display("FAIL alu_wb_done got=%b exp=1", wb_done); end
        checks++; if ({fpr_we, cr_we, wb_busy} !== 3'b0) begin failures++; $display("FAIL alu_others got=%b exp=000", {fpr_we, cr_we, wb_busy}); end
`ifdef WB_FORWARD_EN
        checks++; if ({fwd_valid, fwd_is_fpr, fwd_rd, fwd_data} !== {1'b1, 1'b0, 5'd7, 32'h2A}) begin
            failures++; $display("FAIL alu_fwd got=%b/%b/%0d/%h exp=1/0/7/0000002a", fwd_valid, fwd_is_fpr, fwd_rd, fwd_data); end
`endif
        tick();
        checks++; if ({gpr_we, wb_done} !== 2'b00) begin failures++; $display("FAIL alu_pulse_end got=%b exp=00", {gpr_we, wb_done}); end
        checks++; if (gpr_waddr !== 5'd7 || gpr_wdata !== 32'h2A) begin
            failures++; $display("FAIL alu_hold got=%0d/%h exp=7/0000002a", gpr_waddr, gpr_wdata); end
    endtask

    task automatic test_compare();
        writeback_en = 1'b1; wb_sel = 3'd3; cr_field = 3'd2; cr_wdata = 4'b1000;
        tick();
        quiet_inputs();
        checks++; if ({cr_we, cr_wfield, cr_wval} !== {1'b1, 3'd2, 4'b1000}) begin
            failures++; $display("FAIL cmp_cr got=%b/%0d/%b exp=1/2/1000", cr_we, cr_wfield, cr_wval); end
        checks++; if ({gpr_we, fpr_we, wb_done} !== 3'b001) begin failures++; $display("FAIL cmp_strobes got=%b exp=001", {gpr_we, fpr_we, wb_done}); end
        tick();
        checks++; if (cr_we !== 1'b0) begin failures++; $display("FAIL cmp_pulse_end got=%b exp=0", cr_we); end
    endtask

    task automatic test_none_and_idle_rvalid();
        writeback_en = 1'b1; wb_sel = 3'd6; wb_rd = 5'd11;
        tick();
        quiet_inputs();
        checks++; if ({gpr_we, fpr_we, cr_we, wb_done} !== 4'b0001) begin
            failures++; $display("FAIL none_sel6 got=%b exp=0001", {gpr_we, fpr_we, cr_we, wb_done}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({gpr_we, fpr_we, wb_done, wb_busy} !== 4'b0) begin
            failures++; $display("FAIL idle_rvalid got=%b exp=0000", {gpr_we, fpr_we, wb_done, wb_busy}); end
    endtask

    task automatic test_load();
        int busy_cycles;
        busy_cycles = 0;
        writeback_en = 1'b1; wb_sel = 3'd5; wb_rd = 5'd3; f_dout = 32'h2222_2222;
        tick();
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            if (wb_busy === 1'b1) busy_cycles++;
            tick();
        end
        if (wb_busy === 1'b1) busy_cycles++;
        checks++; if (busy_cycles !== 4) begin failures++; $display("FAIL load_busy_cycles got=%0d exp=4", busy_cycles); end
        // Data arrives on the same cycle the counter hits the limit: data must win.
        mem_rvalid = 1'b1; mem_rdata = 32'h3F80_0000;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({fpr_we, fpr_waddr, fpr_wdata} !== {1'b1, 5'd3, 32'h3F80_0000}) begin
            failures++; $display("FAIL load_fpr got=%b/%0d/%h exp=1/3/3f800000", fpr_we, fpr_waddr, fpr_wdata); end
        checks++; if ({wb_done, wb_busy, gpr_we, load_timeout} !== 4'b1000) begin
            failures++; $display("FAIL load_status got=%b exp=1000", {wb_done, wb_busy, gpr_we, load_timeout}); end
        tick();
        // Fastest load into r0: rvalid right after entering WAIT_MEM.
        writeback_en = 1'b1; wb_sel = 3'd4; wb_rd = 5'd0;
        tick();
        writeback_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        quiet_inputs();
        checks++; if ({gpr_we, gpr_waddr, gpr_wdata, wb_done} !== {1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1}) begin
            failures++; $display("FAIL load_fast_r0 got=%b/%0d/%h/%b exp=1/0/deadbeef/1", gpr_we, gpr_waddr, gpr_wdata, wb_done); end
        tick();
    endtask

    task automatic test_timeout();
        writeback_en = 1'b1; wb_sel = 3'd4; wb_rd = 5'd12;
        tick();
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({wb_busy, load_timeout, wb_done} !== 3'b100) begin
                failures++; $display("FAIL tmo_wait%0d got=%b exp=100", i, {wb_busy, load_timeout, wb_done}); end
        end
        tick();
        checks++; if ({load_timeout, wb_done, gpr_we, wb_busy} !== 4'b1100) begin
            failures++; $display("FAIL tmo_fire got=%b exp=1100", {load_timeout, wb_done, gpr_we, wb_busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({gpr_we, wb_done, load_timeout} !== 3'b001) begin
            failures++; $display("FAIL tmo_late_rvalid got=%b exp=001", {gpr_we, wb_done, load_timeout}); end
    endtask

    task automatic test_overrun();
        writeback_en = 1'b1; wb_sel = 3'd4; wb_rd = 5'd20;
        tick();
        wb_sel = 3'd1; wb_rd = 5'd9; dout = 32'h0000_0099;
        tick();
        quiet_inputs();
        checks++; if ({wb_overrun, gpr_we, wb_busy} !== 3'b101) begin
            failures++; $display("FAIL ovr_flag got=%b exp=101", {wb_overrun, gpr_we, wb_busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({gpr_we, gpr_waddr, gpr_wdata, wb_done} !== {1'b1, 5'd20, 32'h1234, 1'b1}) begin
            failures++; $display("FAIL ovr_load got=%b/%0d/%h/%b exp=1/20/00001234/1", gpr_we, gpr_waddr, gpr_wdata, wb_done); end
        tick();
        checks++; if ({wb_overrun, gpr_we} !== 2'b10) begin failures++; $display("FAIL ovr_sticky got=%b exp=10", {wb_overrun, gpr_we}); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_alu();
        test_compare();
        test_none_and_idle_rvalid();
        test_load();
        test_timeout();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
